// File: rtl/fifo_ctl.sv
// fifo_ctl: single-clock show-ahead FIFO controller for an external sync dual-port RAM.
// Optional: define FIFO_CTL_ERR_EN for sticky overflow/underflow flags on err_o.
module fifo_ctl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W+1:0] level_o,
  output logic [1:0]        err_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic              ram_wr_en_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
);

  localparam int NOB = RD_LAT + 1;
  localparam int IW  = $clog2(NOB);
  localparam int CW  = $clog2(NOB + 1);
  localparam int LW  = ADDR_W + 2;
  localparam int PW  = ADDR_W + 1;
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [PW-1:0]     wr_ptr, rd_ptr, ram_cnt;
  logic [RD_LAT-1:0] infl;
  logic [RD_LAT:0]   infl_nxt;
  logic [DATA_W-1:0] obuf [NOB];
  logic [IW-1:0]     head, tail;
  logic [CW-1:0]     obuf_cnt, infl_cnt;
  logic [LW-1:0]     occ;
  logic              push, pop, issue, ret;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (p == IW'(NOB - 1)) ? '0 : p + IW'(1);
  endfunction

  assign ram_cnt  = wr_ptr - rd_ptr;
  assign full_o   = (ram_cnt == FULL_CNT);
  assign push     = wr_i & ~full_o;
  assign pop      = rd_i & rd_valid_o;
  assign ret      = infl[RD_LAT-1];
  assign infl_nxt = {infl, issue};

  // a returning word always has a free slot: issue only while credit remains
  assign occ   = LW'(obuf_cnt) + LW'(infl_cnt) - LW'(pop);
  assign issue = (ram_cnt != '0) && (occ < LW'(NOB));

  assign ram_wr_en_o   = push;
  assign ram_wr_addr_o = wr_ptr[ADDR_W-1:0];
  assign ram_wr_data_o = wr_data_i;
  assign ram_rd_addr_o = rd_ptr[ADDR_W-1:0];

  assign rd_valid_o = (obuf_cnt != '0);
  assign rd_data_o  = obuf[head];
  assign level_o    = LW'(ram_cnt) + LW'(infl_cnt) + LW'(obuf_cnt);

  // count reads still travelling through the RAM pipeline
  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++)
      infl_cnt = infl_cnt + CW'(infl[i]);
  end

  // RAM write/read pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // issue flags aligned with the RAM read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) infl <= '0;
    else       infl <= infl_nxt[RD_LAT-1:0];
  end

  // output buffer catching returning words, head is the show-ahead word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NOB; i++) obuf[i] <= '0;
      head     <= '0;
      tail     <= '0;
      obuf_cnt <= '0;
    end else begin
      if (ret) begin
        obuf[tail] <= ram_rd_data_i;
        tail       <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      obuf_cnt <= obuf_cnt + CW'(ret) - CW'(pop);
    end
  end

`ifdef FIFO_CTL_ERR_EN
  logic [1:0] err_q;

  // sticky overflow / underflow flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else begin
      if (wr_i && full_o)      err_q[0] <= 1'b1;
      if (rd_i && !rd_valid_o) err_q[1] <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl: directed bench for fifo_ctl with ADDR_W=4, RD_LAT=2 and a RAM model.
// Expected err_o follows FIFO_CTL_ERR_EN when the bench is built with it.
module tb_fifo_ctl;

  localparam int DW = 16;
  localparam int AW = 4;

`ifdef FIFO_CTL_ERR_EN
  localparam logic [1:0] E_OVF = 2'b01;
  localparam logic [1:0] E_UDF = 2'b10;
`else
  localparam logic [1:0] E_OVF = 2'b00;
  localparam logic [1:0] E_UDF = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          wr_i = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          rd_i = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW+1:0] level;
  logic [1:0]    err;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_s1;

  int vecs = 0;
  int errs = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_ctl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .wr_i(wr_i),
    .wr_data_i(wr_data),
    .full_o(full),
    .rd_i(rd_i),
    .rd_data_o(rd_data),
    .rd_valid_o(rd_valid),
    .level_o(level),
    .err_o(err),
    .ram_wr_addr_o(ram_wr_addr),
    .ram_wr_en_o(ram_wr_en),
    .ram_wr_data_o(ram_wr_data),
    .ram_rd_addr_o(ram_rd_addr),
    .ram_rd_data_i(ram_rd_data)
  );

  // two-clock registered-output RAM
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_s1       <= mem[ram_rd_addr];
    ram_rd_data <= rd_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    wr_i = 1'b0;
    rd_i = 1'b0;
    wr_data = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_full"}, 32'(full), 32'(0));
    chk({tag, "_valid"}, 32'(rd_valid), 32'(0));
    chk({tag, "_level"}, 32'(level), 32'(0));
  endtask

  task automatic drain(input int n, input string tag);
    int got;
    got = 0;
    for (int c = 0; c < 4 * n + 10 && got < n; c++) begin
      if (rd_valid) begin
        chk(tag, 32'(rd_data), 32'(exp_q.pop_front()));
        got++;
        rd_i = 1'b1;
      end else begin
        rd_i = 1'b0;
      end
      tick();
    end
    rd_i = 1'b0;
    chk({tag, "_cnt"}, 32'(got), 32'(n));
  endtask

  initial begin
    // reset values
    do_reset();
    chk_idle("rst");
    chk("rst_data", 32'(rd_data), 32'(0));
    chk("rst_wen", 32'(ram_wr_en), 32'(0));
    chk("rst_waddr", 32'(ram_wr_addr), 32'(0));
    chk("rst_raddr", 32'(ram_rd_addr), 32'(0));
    chk("rst_err", 32'(err), 32'(0));

    // single push latency
    wr_i = 1'b1;
    wr_data = 16'h1234;
    #1;
    chk("lat_wen", 32'(ram_wr_en), 32'(1));
    chk("lat_wdata", 32'(ram_wr_data), 32'h1234);
    tick();
    wr_i = 1'b0;
    chk("lat_lvl_c1", 32'(level), 32'(1));
    chk("lat_vld_c1", 32'(rd_valid), 32'(0));
    chk("lat_raddr_c1", 32'(ram_rd_addr), 32'(0));
    tick();
    chk("lat_raddr_c2", 32'(ram_rd_addr), 32'(1));
    tick();
    chk("lat_vld_c3", 32'(rd_valid), 32'(0));
    chk("lat_lvl_c3", 32'(level), 32'(1));
    tick();
    chk("lat_vld_c4", 32'(rd_valid), 32'(1));
    chk("lat_data_c4", 32'(rd_data), 32'h1234);
    chk("lat_lvl_c4", 32'(level), 32'(1));
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    chk_idle("lat_pop");

    // fill to full, 20th push dropped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_i = 1'b1;
      wr_data = 16'(i);
      if (i < 19) exp_q.push_back(16'(i));
      #1;
      if (i == 18) chk("full_c18", 32'(full), 32'(0));
      if (i == 19) begin
        chk("full_c19", 32'(full), 32'(1));
        chk("full_wen", 32'(ram_wr_en), 32'(0));
      end
      tick();
    end
    wr_i = 1'b0;
    chk("full_lvl", 32'(level), 32'(19));
    chk("full_flag", 32'(full), 32'(1));
    chk("full_err", 32'(err), 32'(E_OVF));
    drain(19, "full_drain");
    chk_idle("full_end");

    // steady push+pop at level 10
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_i = 1'b1;
      wr_data = 16'h2000 + 16'(i);
      exp_q.push_back(wr_data);
      tick();
    end
    wr_i = 1'b0;
    repeat (5) tick();
    chk("ss_lvl0", 32'(level), 32'(10));
    for (int k = 0; k < 100; k++) begin
      chk("ss_vld", 32'(rd_valid), 32'(1));
      chk("ss_data", 32'(rd_data), 32'(exp_q.pop_front()));
      chk("ss_lvl", 32'(level), 32'(10));
      wr_i = 1'b1;
      wr_data = 16'h3000 + 16'(k);
      exp_q.push_back(wr_data);
      rd_i = 1'b1;
      tick();
    end
    wr_i = 1'b0;
    rd_i = 1'b0;
    drain(10, "ss_drain");
    chk_idle("ss_end");

    // pop on empty
    do_reset();
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    chk_idle("udf");
    chk("udf_raddr", 32'(ram_rd_addr), 32'(0));
    chk("udf_err", 32'(err), 32'(E_UDF));

    // 40 words streamed through, pointers wrap
    do_reset();
    for (int i = 0; i < 40; i++) begin
      wr_i = 1'b1;
      wr_data = 16'h5000 + 16'(i);
      exp_q.push_back(wr_data);
      if (rd_valid) begin
        chk("wrap_data", 32'(rd_data), 32'(exp_q.pop_front()));
        rd_i = 1'b1;
      end else begin
        rd_i = 1'b0;
      end
      tick();
    end
    wr_i = 1'b0;
    rd_i = 1'b0;
    drain(exp_q.size(), "wrap_drain");
    chk_idle("wrap_end");

    // reset with two reads in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_i = 1'b1;
      wr_data = 16'hA000 + 16'(i);
      tick();
    end
    wr_i = 1'b0;
    chk("mid_lvl", 32'(level), 32'(3));
    chk("mid_vld", 32'(rd_valid), 32'(0));
    rst_i = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_data", 32'(rd_data), 32'(0));
    chk("mid_rst_wen", 32'(ram_wr_en), 32'(0));
    chk("mid_rst_waddr", 32'(ram_wr_addr), 32'(0));
    chk("mid_rst_raddr", 32'(ram_rd_addr), 32'(0));
    chk("mid_rst_err", 32'(err), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    chk_idle("post_rst");
    wr_i = 1'b1;
    wr_data = 16'hBEEF;
    exp_q.push_back(wr_data);
    #1;
    chk("post_waddr", 32'(ram_wr_addr), 32'(0));
    tick();
    wr_i = 1'b0;
    drain(1, "post_drain");
    chk_idle("post_end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
